// File: rtl/cmd_executor.sv
// Command executor: decodes W/R/C commands against an NREGS x 8 register file
// and returns a status byte (plus a data byte for reads) toward a UART transmitter.
module cmd_executor #(
    parameter int NREGS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       cmd_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       cmd_drop
);

    localparam int         AW      = $clog2(NREGS);
    localparam logic [8:0] NREGS_W = 9'(NREGS);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND_STAT = 2'd1;
    localparam logic [1:0] SEND_DATA = 2'd2;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] ST_K  = 8'h4B;
    localparam logic [7:0] ST_D  = 8'h44;
    localparam logic [7:0] ST_E  = 8'h45;

    logic [1:0]    state_q,   state_d;
    logic [7:0]    regs_q [NREGS];
    logic [7:0]    regs_d [NREGS];
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic          cmd_drop_q, cmd_drop_d;
    logic          addr_ok;
    logic [AW-1:0] idx;

    assign addr_ok = ({1'b0, addr} < NREGS_W);
    assign idx     = addr[AW-1:0];

    // All outputs come from flops or state, so cmd_ready/tx_ready never reach them combinationally.
    assign busy     = (state_q != IDLE);
    assign tx_valid = (state_q != IDLE);
    assign tx_data  = tx_data_q;
    assign cmd_drop = cmd_drop_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        regs_d     = regs_q;
        tx_data_d  = tx_data_q;
        rd_byte_d  = rd_byte_q;
        cmd_drop_d = cmd_ready && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (cmd_ready) begin
                    state_d = SEND_STAT;
                    if (cmd == CMD_W && addr_ok) begin
                        regs_d[idx] = data;
                        tx_data_d   = ST_K;
                    end else if (cmd == CMD_R && addr_ok) begin
                        rd_byte_d = regs_q[idx];
                        tx_data_d = ST_D;
                    end else if (cmd == CMD_C) begin
                        for (int i = 0; i < NREGS; i++) regs_d[i] = 8'h00;
                        tx_data_d = ST_K;
                    end else begin
                        tx_data_d = ST_E;
                    end
                end
            end
            SEND_STAT: begin
                if (tx_ready) begin
                    if (tx_data_q == ST_D) begin
                        state_d   = SEND_DATA;
                        tx_data_d = rd_byte_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SEND_DATA: begin
                if (tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is reset explicitly because clear-on-reset is visible behaviour.
            state_q    <= IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
            tx_data_q  <= 8'h00;
            rd_byte_q  <= 8'h00;
            cmd_drop_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            regs_q     <= regs_d;
            tx_data_q  <= tx_data_d;
            rd_byte_q  <= rd_byte_d;
            cmd_drop_q <= cmd_drop_d;
        end
    end

endmodule
